// File: rtl/axi_read_responder.sv
// axi_read_responder: AXI4 read-channel slave that streams bursts out of a
// backing memory whose read data arrives exactly one cycle after mem_req.
// One burst is in progress at a time. Illegal requests still get their beats,
// returned as zero data with an SLVERR response and no memory traffic.
module axi_read_responder #(
    parameter int ADDR_W           = 64,
    parameter int FIRST_BEAT_DELAY = 4,
    parameter int MAX_LEN          = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [63:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata
);

    localparam int DelayW = (FIRST_BEAT_DELAY > 1) ? $clog2(FIRST_BEAT_DELAY) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, STREAM, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] startAddr_q, startAddr_d;
    logic [7:0]        len_q, len_d;
    logic              fixed_q, fixed_d;
    logic              err_q, err_d;
    logic [DelayW-1:0] delay_q, delay_d;
    logic [8:0]        issued_q, issued_d;

    logic              inFlight_q;
    logic [7:0]        pushIdx_q;
    logic [63:0]       fifoData_q [2];
    logic [1:0]        fifoResp_q [2];
    logic [1:0]        fifoLast_q;
    logic              rdPtr_q, wrPtr_q;
    logic [1:0]        occ_q;

    logic              arHs;
    logic              arErr;
    logic              pop;
    logic              issue;
    logic              headLast;
    logic [8:0]        lenPlus1;
    logic [2:0]        creditUsed;

    assign lenPlus1 = {1'b0, len_q} + 9'd1;
    assign arHs     = s_axi_arvalid && (state_q == IDLE);
    assign arErr    = (s_axi_arsize != 3'd3) || s_axi_arburst[1]
                   || (int'(s_axi_arlen) > MAX_LEN) || (s_axi_araddr[2:0] != 3'd0);
    assign pop      = (occ_q != 2'd0) && s_axi_rready;
    assign headLast = fifoLast_q[rdPtr_q];

    // A beat leaving the FIFO this cycle frees its slot for a read issued now,
    // which is what lets a burst stream at one beat per cycle.
    assign creditUsed = {1'b0, occ_q} + {2'b00, inFlight_q} - {2'b00, pop};
    assign issue      = (state_q == STREAM) && (issued_q < lenPlus1) && (creditUsed < 3'd2);

    assign s_axi_arready = (state_q == IDLE);
    assign mem_req       = issue && !err_q;
    assign mem_addr      = !mem_req ? '0
                         : fixed_q  ? startAddr_q
                         :            startAddr_q + ADDR_W'({issued_q, 3'b000});

    assign s_axi_rvalid = (occ_q != 2'd0);
    assign s_axi_rdata  = s_axi_rvalid ? fifoData_q[rdPtr_q] : 64'd0;
    assign s_axi_rresp  = s_axi_rvalid ? fifoResp_q[rdPtr_q] : 2'b00;
    assign s_axi_rlast  = s_axi_rvalid && headLast;

    // Burst control: capture the request, wait out the first-beat delay, issue reads, drain.
    always_comb begin
        state_d     = state_q;
        startAddr_d = startAddr_q;
        len_d       = len_q;
        fixed_d     = fixed_q;
        err_d       = err_q;
        delay_d     = delay_q;
        issued_d    = issue ? issued_q + 9'd1 : issued_q;

        case (state_q)
            IDLE: begin
                if (arHs) begin
                    startAddr_d = s_axi_araddr;
                    len_d       = s_axi_arlen;
                    fixed_d     = (s_axi_arburst == 2'b00);
                    err_d       = arErr;
                    issued_d    = 9'd0;
                    if (FIRST_BEAT_DELAY == 0) begin
                        state_d = STREAM;
                    end else begin
                        state_d = DELAY;
                        delay_d = DelayW'(FIRST_BEAT_DELAY - 1);
                    end
                end
            end
            DELAY: begin
                if (delay_q == '0) begin
                    state_d = STREAM;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            STREAM: begin
                if (issue && (issued_q + 9'd1 == lenPlus1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && headLast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            startAddr_q <= '0;
            len_q       <= '0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
            delay_q     <= '0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            startAddr_q <= startAddr_d;
            len_q       <= len_d;
            fixed_q     <= fixed_d;
            err_q       <= err_d;
            delay_q     <= delay_d;
            issued_q    <= issued_d;
        end
    end

    // Two-entry beat FIFO, filled the cycle after each issued read and drained by R handshakes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inFlight_q    <= 1'b0;
            pushIdx_q     <= '0;
            fifoData_q[0] <= '0;
            fifoData_q[1] <= '0;
            fifoResp_q[0] <= '0;
            fifoResp_q[1] <= '0;
            fifoLast_q    <= '0;
            rdPtr_q       <= 1'b0;
            wrPtr_q       <= 1'b0;
            occ_q         <= '0;
        end else begin
            inFlight_q <= issue;
            if (inFlight_q) begin
                fifoData_q[wrPtr_q] <= err_q ? 64'd0 : mem_rdata;
                fifoResp_q[wrPtr_q] <= err_q ? 2'b10 : 2'b00;
                fifoLast_q[wrPtr_q] <= (pushIdx_q == len_q);
                wrPtr_q             <= ~wrPtr_q;
                pushIdx_q           <= pushIdx_q + 8'd1;
            end
            if (arHs) begin
                pushIdx_q <= '0;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({inFlight_q, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: randomized scoreboard bench for axi_read_responder.
// Two instances are used, one with a 4-cycle first-beat delay and one with none.
module tb_axi_read_responder;

    localparam int D0 = 4;
    localparam int D1 = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    logic        arvalid0, arready0, rvalid0, rready0, rlast0, memReq0;
    logic [63:0] araddr0, rdata0, memAddr0;
    logic [63:0] memRdata0 = 64'd0;
    logic [7:0]  arlen0;
    logic [2:0]  arsize0;
    logic [1:0]  arburst0, rresp0;

    logic        arvalid1, arready1, rvalid1, rready1, rlast1, memReq1;
    logic [63:0] araddr1, rdata1, memAddr1;
    logic [63:0] memRdata1 = 64'd0;
    logic [7:0]  arlen1;
    logic [2:0]  arsize1;
    logic [1:0]  arburst1, rresp1;

    beat_t       expQ[$];
    logic [63:0] memQ[$];

    int errors = 0;
    int checks = 0;
    int cycCnt = 0;
    int active = 0;
    int hsCyc = 0;
    int issuedCnt = 0;
    int retiredCnt = 0;
    int rrMode = 0;
    bit firstSeen = 1'b1;
    bit expectArready = 1'b0;

    axi_read_responder #(.ADDR_W(64), .FIRST_BEAT_DELAY(D0), .MAX_LEN(15)) dut0 (
        .clk(clk), .reset(reset),
        .s_axi_arvalid(arvalid0), .s_axi_arready(arready0), .s_axi_araddr(araddr0),
        .s_axi_arlen(arlen0), .s_axi_arsize(arsize0), .s_axi_arburst(arburst0),
        .s_axi_rvalid(rvalid0), .s_axi_rready(rready0), .s_axi_rdata(rdata0),
        .s_axi_rresp(rresp0), .s_axi_rlast(rlast0),
        .mem_req(memReq0), .mem_addr(memAddr0), .mem_rdata(memRdata0)
    );

    axi_read_responder #(.ADDR_W(64), .FIRST_BEAT_DELAY(D1), .MAX_LEN(15)) dut1 (
        .clk(clk), .reset(reset),
        .s_axi_arvalid(arvalid1), .s_axi_arready(arready1), .s_axi_araddr(araddr1),
        .s_axi_arlen(arlen1), .s_axi_arsize(arsize1), .s_axi_arburst(arburst1),
        .s_axi_rvalid(rvalid1), .s_axi_rready(rready1), .s_axi_rdata(rdata1),
        .s_axi_rresp(rresp1), .s_axi_rlast(rlast1),
        .mem_req(memReq1), .mem_addr(memAddr1), .mem_rdata(memRdata1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure first-beat latency.
    always @(posedge clk) cycCnt <= cycCnt + 1;

    // Contents of the backing memory as a pure function of the byte address.
    function automatic logic [63:0] memFn(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ {a[31:0], a[63:32]};
    endfunction

    // Memory model: data for a request appears one cycle later, junk otherwise.
    always @(posedge clk) begin
        memRdata0 <= memReq0 ? memFn(memAddr0) : 64'hBAD0_BAD0_BAD0_BAD0;
        memRdata1 <= memReq1 ? memFn(memAddr1) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: enqueue the beats and memory addresses a legal responder must produce.
    task automatic applyStimulus(input int inst, input logic [63:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        bit    err;
        bit    got;
        beat_t b;
        logic [63:0] a;
        err = (size != 3'd3) || (burst > 2'd1) || (len > 8'd15) || (addr[2:0] != 3'd0);
        for (int k = 0; k <= int'(len); k++) begin
            a      = (burst == 2'b00) ? addr : addr + 64'(k) * 64'd8;
            b.data = err ? 64'd0 : memFn(a);
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (k == int'(len));
            expQ.push_back(b);
            if (!err) memQ.push_back(a);
        end
        issuedCnt  = 0;
        retiredCnt = 0;
        firstSeen  = 1'b0;
        active     = inst;
        @(posedge clk);
        #1;
        if (inst == 0) begin
            arvalid0 = 1'b1; araddr0 = addr; arlen0 = len; arsize0 = size; arburst0 = burst;
        end else begin
            arvalid1 = 1'b1; araddr1 = addr; arlen1 = len; arsize1 = size; arburst1 = burst;
        end
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if ((inst == 0) ? arready0 : arready1) begin
                hsCyc = cycCnt;
                got   = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ar_handshake: arready never rose, expected within 100 cycles");
        end
        @(posedge clk);
        #1;
        arvalid0 = 1'b0;
        arvalid1 = 1'b0;
    endtask

    // Wait (bounded) for every expected beat to be retired, then idle a few cycles.
    task automatic waitDone(input int maxCyc);
        for (int t = 0; t < maxCyc && expQ.size() != 0; t++) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_timeout: %0d beats outstanding, expected 0", expQ.size());
            expQ.delete();
            memQ.delete();
        end
        checkOutput("mem_reads_outstanding", 64'(memQ.size()), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    // Monitor for the active instance: memory requests, credit limit, and R beats vs scoreboard.
    task automatic monitorInst(input int inst, input logic rv, input logic rr, input logic [63:0] rd,
                               input logic [1:0] rs, input logic rl, input logic arr,
                               input logic mr, input logic [63:0] ma);
        bit    pop;
        beat_t e;
        pop = rv && rr;
        if (expectArready) begin
            checkOutput("arready_after_rlast", 64'(arr), 64'd1);
            expectArready = 1'b0;
        end
        if (mr) begin
            if (memQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mem_req_unexpected: mem_req=1 at 0x%0h, expected 0", ma);
            end else begin
                checkOutput("mem_addr", ma, memQ.pop_front());
            end
            // Reads issued but not yet returned on R may never exceed the two buffer slots.
            checkOutput("credit_limit", 64'((issuedCnt - retiredCnt) < (pop ? 3 : 2)), 64'd1);
            issuedCnt++;
        end
        if (rv) begin
            if (!firstSeen) begin
                firstSeen = 1'b1;
                // Clock edges from the AR handshake edge to the edge that raised rvalid.
                checkOutput("first_beat_latency", 64'(cycCnt - hsCyc - 1),
                            64'(((inst == 0) ? D0 : D1) + 2));
            end
            checkOutput("arready_while_busy", 64'(arr), 64'd0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_unexpected: rdata=0x%0h, expected no beat", rd);
            end else begin
                e = expQ[0];
                checkOutput("rdata", rd, e.data);
                checkOutput("rresp", 64'(rs), 64'(e.resp));
                checkOutput("rlast", 64'(rl), 64'(e.last));
                if (pop) begin
                    void'(expQ.pop_front());
                    retiredCnt++;
                    if (rl) expectArready = 1'b1;
                end
            end
        end
    endtask

    // Monitor process, decoupled from stimulus; sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (active == 0)
                monitorInst(0, rvalid0, rready0, rdata0, rresp0, rlast0, arready0, memReq0, memAddr0);
            else
                monitorInst(1, rvalid1, rready1, rdata1, rresp1, rlast1, arready1, memReq1, memAddr1);
        end
    end

    // rready driver: always ready, the 1-0-0-1 pattern, or random.
    initial begin
        int phase = 0;
        logic r;
        forever begin
            @(posedge clk);
            #1;
            case (rrMode)
                1:       r = (phase == 0) || (phase == 3);
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            phase   = (phase + 1) % 4;
            rready0 = r;
            rready1 = r;
        end
    end

    // Main sequence: reset, directed bursts, random bursts, mid-burst reset.
    initial begin
        logic [63:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
        reset = 1'b0;
        arvalid0 = 1'b0; araddr0 = '0; arlen0 = '0; arsize0 = '0; arburst0 = '0; rready0 = 1'b1;
        arvalid1 = 1'b0; araddr1 = '0; arlen1 = '0; arsize1 = '0; arburst1 = '0; rready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_arready", 64'(arready0), 64'd1);
        checkOutput("reset_rvalid", 64'(rvalid0), 64'd0);
        checkOutput("reset_rdata", rdata0, 64'd0);
        checkOutput("reset_rresp_rlast", 64'({rresp0, rlast0}), 64'd0);
        checkOutput("reset_mem", 64'(memReq0) | memAddr0, 64'd0);
        checkOutput("reset_arready_d0", 64'(arready1), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] INCR len=7 with rready high");
        rrMode = 0;
        applyStimulus(0, 64'h1000, 8'd7, 3'd3, 2'b01);
        waitDone(200);

        $display("[TB] INCR len=7 with rready 1-0-0-1");
        rrMode = 1;
        applyStimulus(0, 64'h1000, 8'd7, 3'd3, 2'b01);
        waitDone(300);

        $display("[TB] FIXED len=0");
        rrMode = 0;
        applyStimulus(0, 64'h2008, 8'd0, 3'd3, 2'b00);
        waitDone(100);

        $display("[TB] size=2 error burst");
        applyStimulus(0, 64'h3000, 8'd3, 3'd2, 2'b01);
        waitDone(100);

        $display("[TB] address wrap with zero first-beat delay");
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01);
        waitDone(100);

        $display("[TB] random bursts");
        rrMode = 2;
        for (int n = 0; n < 24; n++) begin
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 5) != 0) a[2:0] = 3'd0;
            l = 8'($urandom_range(0, 17));
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            b = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            applyStimulus(int'($urandom_range(0, 1)), a, l, s, b);
            waitDone(400);
        end

        $display("[TB] reset in the middle of a burst");
        rrMode = 0;
        applyStimulus(0, 64'h4000, 8'd7, 3'd3, 2'b01);
        for (int t = 0; t < 100 && retiredCnt < 3; t++) @(negedge clk);
        checkOutput("beats_before_reset", 64'(retiredCnt), 64'd3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_rvalid", 64'(rvalid0), 64'd0);
        checkOutput("async_reset_arready", 64'(arready0), 64'd1);
        expQ.delete();
        memQ.delete();
        expectArready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        applyStimulus(0, 64'h5000, 8'd1, 3'd3, 2'b01);
        waitDone(100);
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI4 read-channel responder (slave) that serves burst reads from a backing memory: the far end of the read-initiator interface used by the instruction and data caches.
- Accepts one AR request at a time.
- Waits a programmable first-beat latency, then streams `arlen+1` 64-bit beats on R with full rready backpressure support and correct rlast.
- Used as the memory model in the core testbench and as the memory-side front end of the top-level memory subsystem.

Parameters:
- ADDR_W, 64, address width of araddr and mem_addr.
- FIRST_BEAT_DELAY, 4, idle cycles between AR handshake and first memory read issue (0 allowed).
- MAX_LEN, 15, largest legal arlen; larger values get SLVERR.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- s_axi_arvalid  input  1  read address valid
- s_axi_arready  output  1  read address ready
- s_axi_araddr  input  ADDR_W  burst start byte address
- s_axi_arlen  input  8  beats minus one
- s_axi_arsize  input  3  bytes per beat, log2; only 3 legal
- s_axi_arburst  input  2  00 FIXED, 01 INCR; others illegal
- s_axi_rvalid  output  1  read data valid
- s_axi_rready  input  1  initiator ready for data
- s_axi_rdata  output  64  beat data
- s_axi_rresp  output  2  00 OKAY, 10 SLVERR
- s_axi_rlast  output  1  final beat of burst
- mem_req  output  1  memory read strobe
- mem_addr  output  ADDR_W  8-byte-aligned memory address
- mem_rdata  input  64  memory data, valid exactly 1 cycle after mem_req

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - All outputs 0, except s_axi_arready=1.
  - Buffer emptied; counters cleared.
- Reset asserted mid-burst aborts the burst immediately; no further beats are produced after release.
- States IDLE, DELAY, STREAM, DRAIN.
- IDLE:
  - arready=1.
  - On arvalid&&arready, capture addr, len, burst and error flag.
  - Error flag = (arsize!=3) || (arburst not 00/01) || (arlen>MAX_LEN) || (araddr[2:0]!=0).
  - Go to DELAY, or to STREAM if FIRST_BEAT_DELAY==0.
  - arready=0 in every other state.
- DELAY: count down FIRST_BEAT_DELAY cycles, then STREAM.
- STREAM:
  - Issue reads while (issued < len+1) and (buffer occupancy + reads in flight < 2).
  - mem_req=1 for one cycle per beat.
  - Data is pushed into a 2-entry FIFO on the cycle after mem_req.
  - INCR: mem_addr = start + 8*beat_index.
  - FIXED: mem_addr = start for every beat.
  - Address adds wrap modulo 2^ADDR_W.
  - Error bursts issue no mem_req; they still return len+1 beats with rdata=0 and rresp=10.
  - Go to DRAIN once all beats are issued.
- DRAIN: wait until all beats have been handshaken, then return to IDLE.
- R channel:
  - rvalid = FIFO non-empty; rdata/rresp/rlast come from the FIFO head.
  - rlast=1 only on beat index len.
  - A beat retires on rvalid&&rready.
  - rvalid, rdata, rresp and rlast are held stable while rvalid&&!rready.
- Throughput: with rready tied high, one beat per cycle after the first. First beat's rvalid rises FIRST_BEAT_DELAY+2 cycles after the AR handshake cycle.
- FIFO never overflows; the credit rule guarantees it. A push and a pop in the same cycle leave occupancy unchanged.
- Next AR is accepted only in IDLE. Earliest acceptance is the cycle after the rlast handshake (no overlap of bursts).
- arlen=0: a single beat with rlast=1.

Test Plan:
- Reset high; AR addr=0x1000, len=7, size=3, INCR, rready=1 -> mem_addr 0x1000..0x1038 step 8. Eight beats on consecutive cycles. rlast on beat 7. rresp=00. rvalid first rises 6 cycles after the AR handshake.
- Same burst with rready toggled 1-0-0-1 repeatedly -> no beat is lost or duplicated, data is held stable while stalled, and mem_req pauses when the FIFO is full (occupancy never >2).
- AR len=0, FIXED, addr=0x2008 -> one beat with rlast=1; arready returns to 1 the cycle after the handshake.
- AR size=2, len=3 -> four beats, rdata=0, rresp=10, rlast on the 4th, and zero mem_req pulses.
- FIRST_BEAT_DELAY=0, addr=0xFFFF_FFFF_FFFF_FFF8, len=1, INCR -> mem_addr 0xFFFF_FFFF_FFFF_FFF8 then 0x0.
- Drop reset low after the 3rd beat of a len=7 burst -> rvalid=0 and arready=1 asynchronously. After release, a new AR len=1 returns exactly 2 fresh beats.
